// File: rtl/aes_io_pkg.sv
// Shared types and sizing helpers for the AES word-serial host front end.
package aes_io_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned TMO_W       = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_LAUNCH,
        ST_WAIT_CORE,
        ST_EMIT
    } aes_io_state_t;

    function automatic int unsigned nwords(input int unsigned word_w);
        return AES_BLOCK_W / word_w;
    endfunction

endpackage

// File: rtl/aes_word_pack.sv
// 128-bit word shift register: parallel load, MSB-first serial shift-in and shift-out.
module aes_word_pack
    import aes_io_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [AES_BLOCK_W-1:0] load_data_i,
    input  logic                   shift_i,
    input  logic [WORD_W-1:0]      shift_in_i,
    output logic [WORD_W-1:0]      word_o,
    output logic [AES_BLOCK_W-1:0] shifted_o
);

    logic [AES_BLOCK_W-1:0] data_q, data_d;

    assign shifted_o = {data_q[AES_BLOCK_W-WORD_W-1:0], shift_in_i};
    assign word_o    = data_q[AES_BLOCK_W-1 -: WORD_W];

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = shifted_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/aes_word_io.sv
// Word-serial host front end: assembles keys/text blocks, launches the AES core, streams the result back.
module aes_word_io
    import aes_io_pkg::*;
#(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WORD_W-1:0]      s_data,
    input  logic                   s_is_key,
    input  logic                   s_encrypt,
    output logic [AES_BLOCK_W-1:0] core_key,
    output logic [AES_BLOCK_W-1:0] core_text,
    output logic                   core_start,
    output logic                   core_keyChange,
    output logic                   core_selCypher,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] core_result,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WORD_W-1:0]      m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned NWORDS = nwords(WORD_W);
    localparam int unsigned WCNT_W = $clog2(NWORDS);
    localparam logic [WCNT_W-1:0] WLAST   = WCNT_W'(NWORDS - 1);
    localparam logic [TMO_W-1:0]  TMOLAST = TMO_W'(TIMEOUT - 1);

    aes_io_state_t          state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   blk_type_q, blk_type_d;
    logic                   dir_q, dir_d;
    logic                   key_pending_q, key_pending_d;
    logic                   kp_save_q, kp_save_d;
    logic [AES_BLOCK_W-1:0] core_key_q, core_key_d;
    logic [AES_BLOCK_W-1:0] core_text_q, core_text_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   start_q, start_d;
    logic                   key_chg_q, key_chg_d;
    logic                   sel_cyp_q, sel_cyp_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;

    logic                   s_acc, m_acc, out_load, out_shift;
    logic [AES_BLOCK_W-1:0] in_block, out_shifted;
    logic [WORD_W-1:0]      in_word;
    logic                   unused_pack;

    assign s_acc = s_valid & s_ready_q;
    assign m_acc = m_valid_q & m_ready;

    aes_word_pack #(.WORD_W(WORD_W)) u_in_pack (
        .clk         (clk),
        .rst_n       (reset),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (s_acc),
        .shift_in_i  (s_data),
        .word_o      (in_word),
        .shifted_o   (in_block)
    );

    aes_word_pack #(.WORD_W(WORD_W)) u_out_pack (
        .clk         (clk),
        .rst_n       (reset),
        .load_i      (out_load),
        .load_data_i (core_result),
        .shift_i     (out_shift),
        .shift_in_i  ('0),
        .word_o      (m_data),
        .shifted_o   (out_shifted)
    );

    assign unused_pack = ^{in_word, out_shifted};

    // Next-state, datapath control and registered-output targets
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        tmo_d         = tmo_q;
        blk_type_d    = blk_type_q;
        dir_d         = dir_q;
        key_pending_d = key_pending_q;
        kp_save_d     = kp_save_q;
        core_key_d    = core_key_q;
        core_text_d   = core_text_q;
        out_load      = 1'b0;
        out_shift     = 1'b0;
        err_d         = core_done && (state_q != ST_WAIT_CORE);

        case (state_q)
            ST_IDLE: begin
                if (s_acc) begin
                    blk_type_d = s_is_key;
                    if (!s_is_key) dir_d = s_encrypt;
                    wcnt_d  = WCNT_W'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (s_acc) begin
                    if (s_is_key != blk_type_q) begin
                        // Type switch mid-block: restart with this word as word 0
                        err_d      = 1'b1;
                        blk_type_d = s_is_key;
                        if (!s_is_key) dir_d = s_encrypt;
                        wcnt_d     = WCNT_W'(1);
                    end else if (wcnt_q == WLAST) begin
                        wcnt_d = '0;
                        if (blk_type_q) begin
                            core_key_d    = in_block;
                            key_pending_d = 1'b1;
                            state_d       = ST_IDLE;
                        end else begin
                            core_text_d = in_block;
                            state_d     = ST_LAUNCH;
                        end
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_LAUNCH: begin
                kp_save_d     = key_pending_q;
                key_pending_d = 1'b0;
                tmo_d         = '0;
                state_d       = ST_WAIT_CORE;
            end
            ST_WAIT_CORE: begin
                if (core_done) begin
                    out_load = 1'b1;
                    state_d  = ST_EMIT;
                end else if (tmo_q == TMOLAST) begin
                    err_d         = 1'b1;
                    key_pending_d = kp_save_q;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_EMIT: begin
                if (m_acc) begin
                    out_shift = 1'b1;
                    if (wcnt_q == WLAST) begin
                        wcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
        busy_d    = (state_d != ST_IDLE);
        start_d   = (state_d == ST_LAUNCH);
        key_chg_d = start_d & key_pending_q;
        sel_cyp_d = start_d & dir_d;
        m_valid_d = (state_d == ST_EMIT);
        m_last_d  = m_valid_d && (wcnt_d == WLAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            wcnt_q        <= '0;
            tmo_q         <= '0;
            blk_type_q    <= 1'b0;
            dir_q         <= 1'b0;
            key_pending_q <= 1'b0;
            kp_save_q     <= 1'b0;
            core_key_q    <= '0;
            core_text_q   <= '0;
            s_ready_q     <= 1'b1;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            start_q       <= 1'b0;
            key_chg_q     <= 1'b0;
            sel_cyp_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            tmo_q         <= tmo_d;
            blk_type_q    <= blk_type_d;
            dir_q         <= dir_d;
            key_pending_q <= key_pending_d;
            kp_save_q     <= kp_save_d;
            core_key_q    <= core_key_d;
            core_text_q   <= core_text_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            start_q       <= start_d;
            key_chg_q     <= key_chg_d;
            sel_cyp_q     <= sel_cyp_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
        end
    end

    assign s_ready        = s_ready_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign core_key       = core_key_q;
    assign core_text      = core_text_q;
    assign core_start     = start_q;
    assign core_keyChange = key_chg_q;
    assign core_selCypher = sel_cyp_q;
    assign m_valid        = m_valid_q;
    assign m_last         = m_last_q;

endmodule

// File: doc/aes_word_io.md
Name: aes_word_io

Overview:
- Host-side word-serial front end for the AES-128 core. It is the other end of the core controller's start/keyChange/selCypher control interface.
- Deserialises 128-bit keys and text blocks from a WORD_W-bit valid/ready input stream, then launches the core with the correct keyChange/selCypher qualifiers.
- Captures the 128-bit core result and serialises it onto a valid/ready output stream.
- Sits between the bus/DMA fabric and the AES core top.

Parameters:
- WORD_W, 32, stream word width; legal values 8, 16, 32. NWORDS = 128/WORD_W.
- TIMEOUT, 64, maximum cycles in WAIT_CORE before abort; legal range 16..1023.

Ports:
- clk  in  1  main clock
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid&&s_ready
- s_data  in  WORD_W  input word, MSB-first order
- s_is_key  in  1  1 = word belongs to a key, 0 = word belongs to a text block
- s_encrypt  in  1  direction; sampled with word 0 of a text block (1 = encrypt)
- core_key  out  128  assembled key, held stable
- core_text  out  128  assembled text block, held stable
- core_start  out  1  one-cycle launch pulse
- core_keyChange  out  1  qualifies core_start; new key must be expanded
- core_selCypher  out  1  qualifies core_start; 1 = encrypt
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  128  result, valid with core_done
- m_valid  out  1  output word valid
- m_ready  in  1  output word accepted
- m_data  out  WORD_W  result word, MSB-first order
- m_last  out  1  marks word NWORDS-1
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle error pulse

Behaviour:
- Reset values: state IDLE; core_key, core_text, m_data = 0; core_start, core_keyChange, core_selCypher, m_valid, m_last, err, busy = 0; key_pending = 0; s_ready = 1 after reset release.
- States: IDLE, COLLECT, LAUNCH, WAIT_CORE, EMIT.
- Word packing:
  - Word k of a block lands in bits [127-k*WORD_W -: WORD_W].
  - The word counter wcnt is clog2(NWORDS) bits wide and wraps to 0 after NWORDS-1.
- s_ready = 1 in IDLE and COLLECT only.
- IDLE -> COLLECT on an accepted word, which is stored as word 0. Its s_is_key is latched as blk_type. If blk_type = 0, s_encrypt is latched as dir.
- COLLECT:
  - Each accepted word increments wcnt.
  - If s_is_key differs from blk_type on an accepted word: discard the partial block, pulse err, and treat the word as a new word 0 with the new type.
  - Last key word accepted: core_key updated, key_pending <= 1, go to IDLE. No launch.
  - Last text word accepted at cycle t: go to LAUNCH at t+1.
- LAUNCH (one cycle):
  - core_start = 1, core_selCypher = dir, core_keyChange = key_pending.
  - Clear key_pending, reset the timeout counter, then go to WAIT_CORE.
- WAIT_CORE:
  - On core_done: capture core_result, go to EMIT next cycle.
  - If TIMEOUT cycles pass without core_done: pulse err and go to IDLE. key_pending is restored to its value before the launch.
  - core_done in any state other than WAIT_CORE is ignored and pulses err.
- EMIT:
  - m_valid = 1 and m_data = current result word; m_last = 1 on word NWORDS-1.
  - m_data is held stable while m_ready = 0; there is no limit on backpressure.
  - The final handshake returns to IDLE; s_ready is 1 in the following cycle.
- A text block with no key ever loaded is launched with core_keyChange = 0; keying the core is the host's responsibility.
- Reset asserted mid-operation: immediate return to reset values; the partial block and any pending key are lost.
- Core result latency is invisible to the host apart from busy.

Decomposition:
- aes_io_pkg:
  - state enum aes_io_state_t
  - AES_BLOCK_W = 128
  - function nwords(WORD_W)
  - TIMEOUT counter width constant
- Sub-module aes_word_pack: a shift register parameterised by WORD_W, with parallel load, serial shift-in and serial shift-out. It is instantiated once for input assembly and once for output serialisation.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f (4 words), then encrypt block 00112233445566778899aabbccddeeff -> one core_start with core_keyChange = 1 and core_selCypher = 1. Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> 4 output words in that order, m_last on word 3.
- Second encrypt block with no new key -> core_keyChange = 0 at launch; err never pulses.
- Decrypt block 69c4e0d8... with s_encrypt = 0 -> core_selCypher = 0; output 00112233...eeff.
- Key word 2 followed by a text word -> err pulses once; no launch; the following 3 text words plus one more key block complete normally.
- m_ready held low for 20 cycles on word 1 -> m_data stable and m_valid high throughout; s_ready = 0 until the final word is accepted.
- Core model never asserts done -> err pulses TIMEOUT cycles after LAUNCH, busy drops, and the next block launches with the original key_pending. Also assert reset mid-COLLECT -> s_ready = 1 and busy = 0 after release.
